// File: rtl/bram_dp_param.sv
// Dual-port byte-writable block RAM with a sequenced whole-array clear,
// configurable read latency and same-port write-first/read-first behaviour.
module bram_dp_param #(
    parameter int    DATA_W    = 64,
    parameter int    DEPTH     = 128,
    parameter int    ADDR_W    = 8,
    parameter int    RD_LAT    = 1,
    parameter int    WR_MODE   = 0,
    parameter string INIT_FILE = ""
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  clr,
    output logic                  busy,
    input  logic                  en_a,
    input  logic                  en_b,
    input  logic [DATA_W/8-1:0]   we_a,
    input  logic [DATA_W/8-1:0]   we_b,
    input  logic [ADDR_W-1:0]     addr_a,
    input  logic [ADDR_W-1:0]     addr_b,
    input  logic [DATA_W-1:0]     din_a,
    input  logic [DATA_W-1:0]     din_b,
    output logic [DATA_W-1:0]     dout_a,
    output logic [DATA_W-1:0]     dout_b,
    output logic                  vld_a,
    output logic                  vld_b,
    output logic                  coll
);
    // state | meaning
    // IDLE  | normal port access, clr accepted
    // CLEAR | zeroing one word per cycle, ports ignored
    localparam int                NB      = DATA_W / 8;
    localparam int                IDX_W   = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [ADDR_W:0]   DEPTH_L = (ADDR_W + 1)'(DEPTH);
    localparam logic [IDX_W-1:0]  LAST    = IDX_W'(DEPTH - 1);

    typedef enum logic {IDLE, CLEAR} state_t;

    state_t            state;
    logic [IDX_W-1:0]  clr_idx;
    logic [DATA_W-1:0] mem [DEPTH];

    initial begin
        for (int i = 0; i < DEPTH; i++) mem[i] = '0;
    end

    function automatic logic [DATA_W-1:0] merge(input logic [DATA_W-1:0] base,
                                                input logic [DATA_W-1:0] din,
                                                input logic [NB-1:0]     we);
        logic [DATA_W-1:0] r;
        r = base;
        for (int i = 0; i < NB; i++)
            if (we[i]) r[8*i +: 8] = din[8*i +: 8];
        return r;
    endfunction

    logic             go_a, go_b, ok_a, ok_b, wr_a, wr_b, same;
    logic [IDX_W-1:0] ia, ib;
    logic [DATA_W-1:0] old_a, old_b, new_a, new_b, rd_a, rd_b;

    assign ia   = addr_a[IDX_W-1:0];
    assign ib   = addr_b[IDX_W-1:0];
    assign go_a = en_a & ~busy & ~reset;
    assign go_b = en_b & ~busy & ~reset;
    assign ok_a = {1'b0, addr_a} < DEPTH_L;
    assign ok_b = {1'b0, addr_b} < DEPTH_L;
    assign wr_a = go_a & ok_a & (|we_a);
    assign wr_b = go_b & ok_b & (|we_b);
    assign same = (addr_a == addr_b);

    // A writer sees the word as it will be stored (A wins overlapping bytes);
    // a non-writing reader always sees the pre-write word.
    always_comb begin
        old_a = ok_a ? mem[ia] : '0;
        old_b = ok_b ? mem[ib] : '0;
        new_a = old_a;
        new_b = old_b;
        if (wr_b && same) new_a = merge(new_a, din_b, we_b);
        if (wr_a)         new_a = merge(new_a, din_a, we_a);
        if (wr_b)         new_b = merge(new_b, din_b, we_b);
        if (wr_a && same) new_b = merge(new_b, din_a, we_a);
        rd_a = (WR_MODE == 0 && wr_a) ? new_a : old_a;
        rd_b = (WR_MODE == 0 && wr_b) ? new_b : old_b;
    end

    // Memory contents are deliberately outside the reset domain.
    always_ff @(posedge clk) begin
        if (!reset) begin
            if (state == CLEAR) begin
                mem[clr_idx] <= '0;
            end else begin
                for (int i = 0; i < NB; i++) begin
                    if (wr_b && we_b[i]) mem[ib][8*i +: 8] <= din_b[8*i +: 8];
                    if (wr_a && we_a[i]) mem[ia][8*i +: 8] <= din_a[8*i +: 8];
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state   <= IDLE;
            busy    <= 1'b0;
            clr_idx <= '0;
            coll    <= 1'b0;
        end else begin
            coll <= go_a & go_b & ok_a & ok_b & same & ((|we_a) | (|we_b));
            case (state)
                IDLE: begin
                    if (clr) begin
                        state   <= CLEAR;
                        busy    <= 1'b1;
                        clr_idx <= '0;
                    end
                end
                CLEAR: begin
                    clr_idx <= clr_idx + 1'b1;
                    if (clr_idx == LAST) begin
                        state <= IDLE;
                        busy  <= 1'b0;
                    end
                end
                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

    generate
        if (RD_LAT == 2) begin : g_lat2
            logic              p_vld_a, p_vld_b;
            logic [DATA_W-1:0] p_dat_a, p_dat_b;
            always_ff @(posedge clk) begin
                if (reset) begin
                    p_vld_a <= 1'b0;
                    p_vld_b <= 1'b0;
                    p_dat_a <= '0;
                    p_dat_b <= '0;
                    vld_a   <= 1'b0;
                    vld_b   <= 1'b0;
                    dout_a  <= '0;
                    dout_b  <= '0;
                end else begin
                    p_vld_a <= go_a;
                    p_vld_b <= go_b;
                    if (go_a) p_dat_a <= rd_a;
                    if (go_b) p_dat_b <= rd_b;
                    vld_a <= p_vld_a;
                    vld_b <= p_vld_b;
                    if (p_vld_a) dout_a <= p_dat_a;
                    if (p_vld_b) dout_b <= p_dat_b;
                end
            end
        end else begin : g_lat1
            always_ff @(posedge clk) begin
                if (reset) begin
                    vld_a  <= 1'b0;
                    vld_b  <= 1'b0;
                    dout_a <= '0;
                    dout_b <= '0;
                end else begin
                    vld_a <= go_a;
                    vld_b <= go_b;
                    if (go_a) dout_a <= rd_a;
                    if (go_b) dout_b <= rd_b;
                end
            end
        end
    endgenerate
endmodule

// File: tb/tb_bram_dp_param.sv
// Scoreboard bench: u1 is the default RAM (RD_LAT=1, write-first),
// u2 is RD_LAT=2 read-first. Expected reads carry the cycle they must appear.
module tb_bram_dp_param;
    logic clk = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    logic        clr1, busy1, en_a1, en_b1, vld_a1, vld_b1, coll1;
    logic [7:0]  we_a1, we_b1, addr_a1, addr_b1;
    logic [63:0] din_a1, din_b1, dout_a1, dout_b1;
    logic        clr2, busy2, en_a2, en_b2, vld_a2, vld_b2, coll2;
    logic [7:0]  we_a2, we_b2, addr_a2, addr_b2;
    logic [63:0] din_a2, din_b2, dout_a2, dout_b2;

    bram_dp_param u1 (
        .clk(clk), .reset(reset), .clr(clr1), .busy(busy1),
        .en_a(en_a1), .en_b(en_b1), .we_a(we_a1), .we_b(we_b1),
        .addr_a(addr_a1), .addr_b(addr_b1), .din_a(din_a1), .din_b(din_b1),
        .dout_a(dout_a1), .dout_b(dout_b1), .vld_a(vld_a1), .vld_b(vld_b1),
        .coll(coll1));

    bram_dp_param #(.RD_LAT(2), .WR_MODE(1)) u2 (
        .clk(clk), .reset(reset), .clr(clr2), .busy(busy2),
        .en_a(en_a2), .en_b(en_b2), .we_a(we_a2), .we_b(we_b2),
        .addr_a(addr_a2), .addr_b(addr_b2), .din_a(din_a2), .din_b(din_b2),
        .dout_a(dout_a2), .dout_b(dout_b2), .vld_a(vld_a2), .vld_b(vld_b2),
        .coll(coll2));

    typedef struct {
        logic [63:0] d;
        int          c;
    } exp_t;

    exp_t q[4][$];
    int   cyc = 0;
    int   vectors = 0;
    int   errors = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic mon(input int p, input logic v, input logic [63:0] d);
        exp_t e;
        if (v) begin
            vectors++;
            if (q[p].size() == 0) begin
                errors++;
                $display("FAIL rd_port%0d: unexpected vld, dout=%h at cycle %0d", p, d, cyc);
            end else begin
                e = q[p].pop_front();
                if (d !== e.d || cyc != e.c) begin
                    errors++;
                    $display("FAIL rd_port%0d: got %h at cycle %0d, expected %h at cycle %0d",
                             p, d, cyc, e.d, e.c);
                end
            end
        end
    endtask

    always @(negedge clk) begin
        mon(0, vld_a1, dout_a1);
        mon(1, vld_b1, dout_b1);
        mon(2, vld_a2, dout_a2);
        mon(3, vld_b2, dout_b2);
    end

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        vectors++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic idle_inputs();
        en_a1 = 0; en_b1 = 0; we_a1 = 0; we_b1 = 0;
        en_a2 = 0; en_b2 = 0; we_a2 = 0; we_b2 = 0;
    endtask

    // One access cycle on unit u; xa/xb are the hand-computed read results.
    task automatic acc(input int u,
                       input logic ea, input logic [7:0] wa, input logic [7:0] aa,
                       input logic [63:0] da, input logic [63:0] xa,
                       input logic eb, input logic [7:0] wb, input logic [7:0] ab,
                       input logic [63:0] db, input logic [63:0] xb);
        exp_t e;
        int   lat  = (u == 1) ? 1 : 2;
        int   base = (u == 1) ? 0 : 2;
        if (u == 1) begin
            en_a1 = ea; we_a1 = wa; addr_a1 = aa; din_a1 = da;
            en_b1 = eb; we_b1 = wb; addr_b1 = ab; din_b1 = db;
        end else begin
            en_a2 = ea; we_a2 = wa; addr_a2 = aa; din_a2 = da;
            en_b2 = eb; we_b2 = wb; addr_b2 = ab; din_b2 = db;
        end
        if (ea) begin e.d = xa; e.c = cyc + lat; q[base].push_back(e); end
        if (eb) begin e.d = xb; e.c = cyc + lat; q[base + 1].push_back(e); end
        @(posedge clk);
        #1;
        idle_inputs();
    endtask

    int n;

    initial begin
        clr1 = 0; clr2 = 0;
        addr_a1 = 0; addr_b1 = 0; din_a1 = 0; din_b1 = 0;
        addr_a2 = 0; addr_b2 = 0; din_a2 = 0; din_b2 = 0;
        idle_inputs();
        repeat (3) @(posedge clk);
        #1;
        reset = 0;
        chk("rst_dout_a", dout_a1, 64'h0);
        chk("rst_dout_b", dout_b1, 64'h0);
        chk("rst_vld_a", {63'h0, vld_a1}, 64'h0);
        chk("rst_busy", {63'h0, busy1}, 64'h0);
        chk("rst_coll", {63'h0, coll1}, 64'h0);
        chk("rst_dout_a2", dout_a2, 64'h0);

        // full write, cross-port read, byte-enabled write
        acc(1, 1, 8'hFF, 8'd5, 64'h0123456789ABCDEF, 64'h0123456789ABCDEF, 0, 0, 0, 0, 0);
        acc(1, 0, 0, 0, 0, 0, 1, 8'h00, 8'd5, 64'h0, 64'h0123456789ABCDEF);
        acc(1, 1, 8'h0F, 8'd5, 64'hFFFFFFFFFFFFFFFF, 64'h01234567FFFFFFFF, 0, 0, 0, 0, 0);
        acc(1, 0, 0, 0, 0, 0, 1, 8'h00, 8'd5, 64'h0, 64'h01234567FFFFFFFF);

        // B reads while A writes the same word: B sees the old word
        acc(1, 1, 8'hFF, 8'd6, 64'h1111111111111111, 64'h1111111111111111,
               1, 8'h00, 8'd6, 64'h0, 64'h0);
        chk("coll_rd_wr", {63'h0, coll1}, 64'h1);
        acc(1, 0, 0, 0, 0, 0, 1, 8'h00, 8'd6, 64'h0, 64'h1111111111111111);
        chk("coll_clear", {63'h0, coll1}, 64'h0);

        // dual write collision: A wins every byte
        acc(1, 1, 8'hFF, 8'd9, 64'hAAAAAAAAAAAAAAAA, 64'hAAAAAAAAAAAAAAAA,
               1, 8'hFF, 8'd9, 64'h5555555555555555, 64'hAAAAAAAAAAAAAAAA);
        chk("coll_ww", {63'h0, coll1}, 64'h1);
        acc(1, 1, 8'h00, 8'd9, 64'h0, 64'hAAAAAAAAAAAAAAAA, 0, 0, 0, 0, 0);
        chk("coll_one_cycle", {63'h0, coll1}, 64'h0);

        // partial overlap: byte 0 both (A), byte 1 only B, byte 2 only A
        acc(1, 1, 8'h05, 8'd10, 64'h0000000000CC00AA, 64'h0000000000CCBBAA,
               1, 8'h03, 8'd10, 64'h000000000000BB11, 64'h0000000000CCBBAA);
        acc(1, 1, 8'h00, 8'd10, 64'h0, 64'h0000000000CCBBAA, 0, 0, 0, 0, 0);

        // out-of-range: write dropped, read gives zero, no coll
        acc(1, 1, 8'hFF, 8'd200, 64'h1234, 64'h0, 1, 8'hFF, 8'd200, 64'h5678, 64'h0);
        chk("coll_oor", {63'h0, coll1}, 64'h0);
        acc(1, 1, 8'h00, 8'd200, 64'h0, 64'h0, 1, 8'h00, 8'd72, 64'h0, 64'h0);

        // clear with a concurrent access that must complete first
        clr1 = 1;
        acc(1, 1, 8'hFF, 8'd3, 64'h33, 64'h33, 0, 0, 0, 0, 0);
        clr1 = 0;
        n = 0;
        for (int k = 0; k < 300; k++) begin
            @(negedge clk);
            if (!busy1) break;
            n++;
            en_a1 = n[0];
            we_a1 = 8'hFF;
            addr_a1 = 8'd7;
            din_a1 = 64'hBAD;
            clr1 = n[1];
        end
        idle_inputs();
        clr1 = 0;
        chk("busy_cycles", 64'(n), 64'd128);
        for (int i = 0; i < 128; i++)
            acc(1, 1, 8'h00, 8'(i), 64'h0, 64'h0, 0, 0, 0, 0, 0);

        // reset in clear cycle 40
        acc(1, 1, 8'hFF, 8'd39, 64'h39, 64'h39, 1, 8'hFF, 8'd40, 64'h40, 64'h40);
        acc(1, 1, 8'hFF, 8'd100, 64'h64, 64'h64, 1, 8'hFF, 8'd0, 64'hF0, 64'hF0);
        clr1 = 1;
        acc(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        clr1 = 0;
        repeat (40) @(posedge clk);
        #1;
        reset = 1;
        @(posedge clk);
        #1;
        reset = 0;
        chk("abort_busy", {63'h0, busy1}, 64'h0);
        chk("abort_dout_a", dout_a1, 64'h0);
        for (int i = 0; i < 40; i++)
            acc(1, 1, 8'h00, 8'(i), 64'h0, 64'h0, 0, 0, 0, 0, 0);
        acc(1, 1, 8'h00, 8'd40, 64'h0, 64'h40, 1, 8'h00, 8'd100, 64'h0, 64'h64);

        // RD_LAT=2 read-first unit
        acc(2, 1, 8'hFF, 8'd1, 64'h1111000000000001, 64'h0, 0, 0, 0, 0, 0);
        acc(2, 1, 8'hFF, 8'd2, 64'h2222000000000002, 64'h0, 0, 0, 0, 0, 0);
        acc(2, 1, 8'hFF, 8'd3, 64'h3333000000000003, 64'h0, 0, 0, 0, 0, 0);
        acc(2, 1, 8'h00, 8'd1, 64'h0, 64'h1111000000000001, 0, 0, 0, 0, 0);
        acc(2, 1, 8'h00, 8'd2, 64'h0, 64'h2222000000000002, 0, 0, 0, 0, 0);
        acc(2, 1, 8'h00, 8'd3, 64'h0, 64'h3333000000000003, 0, 0, 0, 0, 0);
        acc(2, 1, 8'hFF, 8'd1, 64'hFFFFFFFFFFFFFFFF, 64'h1111000000000001, 0, 0, 0, 0, 0);
        acc(2, 1, 8'hF0, 8'd2, 64'h9999999900000000, 64'h2222000000000002,
               1, 8'h00, 8'd2, 64'h0, 64'h2222000000000002);
        acc(2, 1, 8'h00, 8'd1, 64'h0, 64'hFFFFFFFFFFFFFFFF,
               1, 8'h00, 8'd2, 64'h0, 64'h9999999900000002);

        repeat (6) @(posedge clk);
        #1;
        for (int p = 0; p < 4; p++)
            chk($sformatf("drain_port%0d", p), 64'(q[p].size()), 64'd0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end
endmodule
